// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: state encodings and port constants shared by the 2:1 AXI-Lite arbiter
package axil_arb_pkg;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} rd_state_t;
  localparam logic PORT0 = 1'b0;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin pick; ptr names the port favoured on a tie
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_grant,
  output logic       o_any
);
  assign o_any   = |i_req;
  assign o_grant = &i_req ? i_ptr : i_req[1];
endmodule

// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: shares one AXI-Lite slave between two masters, independent round-robin write and read channels
module axil_arbiter_2to1
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_s0_awaddr,
  input  logic [2:0]        i_s0_awprot,
  input  logic              i_s0_awvalid,
  output logic              o_s0_awready,
  input  logic [31:0]       i_s0_wdata,
  input  logic [3:0]        i_s0_wstrb,
  input  logic              i_s0_wvalid,
  output logic              o_s0_wready,
  output logic [1:0]        o_s0_bresp,
  output logic              o_s0_bvalid,
  input  logic              i_s0_bready,
  input  logic [ADDR_W-1:0] i_s0_araddr,
  input  logic [2:0]        i_s0_arprot,
  input  logic              i_s0_arvalid,
  output logic              o_s0_arready,
  output logic [31:0]       o_s0_rdata,
  output logic [1:0]        o_s0_rresp,
  output logic              o_s0_rvalid,
  input  logic              i_s0_rready,
  input  logic [ADDR_W-1:0] i_s1_awaddr,
  input  logic [2:0]        i_s1_awprot,
  input  logic              i_s1_awvalid,
  output logic              o_s1_awready,
  input  logic [31:0]       i_s1_wdata,
  input  logic [3:0]        i_s1_wstrb,
  input  logic              i_s1_wvalid,
  output logic              o_s1_wready,
  output logic [1:0]        o_s1_bresp,
  output logic              o_s1_bvalid,
  input  logic              i_s1_bready,
  input  logic [ADDR_W-1:0] i_s1_araddr,
  input  logic [2:0]        i_s1_arprot,
  input  logic              i_s1_arvalid,
  output logic              o_s1_arready,
  output logic [31:0]       o_s1_rdata,
  output logic [1:0]        o_s1_rresp,
  output logic              o_s1_rvalid,
  input  logic              i_s1_rready,
  output logic [ADDR_W-1:0] o_m_awaddr,
  output logic [2:0]        o_m_awprot,
  output logic              o_m_awvalid,
  input  logic              i_m_awready,
  output logic [31:0]       o_m_wdata,
  output logic [3:0]        o_m_wstrb,
  output logic              o_m_wvalid,
  input  logic              i_m_wready,
  input  logic [1:0]        i_m_bresp,
  input  logic              i_m_bvalid,
  output logic              o_m_bready,
  output logic [ADDR_W-1:0] o_m_araddr,
  output logic [2:0]        o_m_arprot,
  output logic              o_m_arvalid,
  input  logic              i_m_arready,
  input  logic [31:0]       i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  input  logic              i_m_rvalid,
  output logic              o_m_rready
);
  wr_state_t r_wst;
  rd_state_t r_rdst;
  logic r_wgnt, r_wptr, r_aw_done, r_w_done, r_rgnt, r_rptr;
  logic w_wpick, w_wany, w_rpick, w_rany;
  logic w_wfwd, w_wresp, w_rfwd, w_rdat;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_awrdy, w_wrdy, w_bv, w_arrdy, w_rv;
  rr_pick2 u_wpick (.i_req({i_s1_awvalid, i_s0_awvalid}), .i_ptr(r_wptr), .o_grant(w_wpick), .o_any(w_wany));
  rr_pick2 u_rpick (.i_req({i_s1_arvalid, i_s0_arvalid}), .i_ptr(r_rptr), .o_grant(w_rpick), .o_any(w_rany));
  assign w_wfwd  = r_wst == W_FWD;
  assign w_wresp = r_wst == W_RESP;
  assign w_rfwd  = r_rdst == R_FWD;
  assign w_rdat  = r_rdst == R_DATA;
  assign o_m_awaddr  = r_wgnt ? i_s1_awaddr : i_s0_awaddr;
  assign o_m_awprot  = r_wgnt ? i_s1_awprot : i_s0_awprot;
  assign o_m_wdata   = r_wgnt ? i_s1_wdata : i_s0_wdata;
  assign o_m_wstrb   = r_wgnt ? i_s1_wstrb : i_s0_wstrb;
  // sticky done flags stop AW or W from being reissued while the other half is still pending
  assign o_m_awvalid = w_wfwd & ~r_aw_done & (r_wgnt ? i_s1_awvalid : i_s0_awvalid);
  assign o_m_wvalid  = w_wfwd & ~r_w_done & (r_wgnt ? i_s1_wvalid : i_s0_wvalid);
  assign o_m_bready  = w_wresp & (r_wgnt ? i_s1_bready : i_s0_bready);
  assign o_m_araddr  = r_rgnt ? i_s1_araddr : i_s0_araddr;
  assign o_m_arprot  = r_rgnt ? i_s1_arprot : i_s0_arprot;
  assign o_m_arvalid = w_rfwd & (r_rgnt ? i_s1_arvalid : i_s0_arvalid);
  assign o_m_rready  = w_rdat & (r_rgnt ? i_s1_rready : i_s0_rready);
  assign w_aw_hs = o_m_awvalid & i_m_awready;
  assign w_w_hs  = o_m_wvalid & i_m_wready;
  assign w_b_hs  = o_m_bready & i_m_bvalid;
  assign w_ar_hs = o_m_arvalid & i_m_arready;
  assign w_r_hs  = o_m_rready & i_m_rvalid;
  assign w_awrdy = w_wfwd & ~r_aw_done & i_m_awready;
  assign w_wrdy  = w_wfwd & ~r_w_done & i_m_wready;
  assign w_bv    = w_wresp & i_m_bvalid;
  assign w_arrdy = w_rfwd & i_m_arready;
  assign w_rv    = w_rdat & i_m_rvalid;
  assign o_s0_awready = w_awrdy & (r_wgnt == PORT0);
  assign o_s1_awready = w_awrdy & (r_wgnt != PORT0);
  assign o_s0_wready  = w_wrdy & (r_wgnt == PORT0);
  assign o_s1_wready  = w_wrdy & (r_wgnt != PORT0);
  assign o_s0_bvalid  = w_bv & (r_wgnt == PORT0);
  assign o_s1_bvalid  = w_bv & (r_wgnt != PORT0);
  assign o_s0_bresp   = i_m_bresp;
  assign o_s1_bresp   = i_m_bresp;
  assign o_s0_arready = w_arrdy & (r_rgnt == PORT0);
  assign o_s1_arready = w_arrdy & (r_rgnt != PORT0);
  assign o_s0_rvalid  = w_rv & (r_rgnt == PORT0);
  assign o_s1_rvalid  = w_rv & (r_rgnt != PORT0);
  assign o_s0_rdata   = i_m_rdata;
  assign o_s1_rdata   = i_m_rdata;
  assign o_s0_rresp   = i_m_rresp;
  assign o_s1_rresp   = i_m_rresp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wst     <= W_IDLE;
      r_wgnt    <= PORT0;
      r_wptr    <= PORT0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wst)
        W_IDLE: if (w_wany) begin
          r_wgnt <= w_wpick;
          r_wst  <= W_FWD;
        end
        W_FWD: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          r_wst     <= W_RESP;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          r_aw_done <= r_aw_done | w_aw_hs;
          r_w_done  <= r_w_done | w_w_hs;
        end
        W_RESP: if (w_b_hs) begin
          r_wst  <= W_IDLE;
          r_wptr <= ~r_wgnt;
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdst <= R_IDLE;
      r_rgnt <= PORT0;
      r_rptr <= PORT0;
    end else begin
      case (r_rdst)
        R_IDLE: if (w_rany) begin
          r_rgnt <= w_rpick;
          r_rdst <= R_FWD;
        end
        R_FWD: if (w_ar_hs) r_rdst <= R_DATA;
        R_DATA: if (w_r_hs) begin
          r_rdst <= R_IDLE;
          r_rptr <= ~r_rgnt;
        end
        default: r_rdst <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb_axil_arbiter_2to1: directed and shadow-checked bench for the 2:1 AXI-Lite arbiter with a RAM slave model
module tb_axil_arbiter_2to1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [11:0] s_awaddr[2], s_araddr[2];
  logic [2:0]  s_prot[2];
  logic [31:0] s_wdata[2], s_rdata[2];
  logic [3:0]  s_wstrb[2];
  logic [1:0]  s_bresp[2], s_rresp[2];
  logic [1:0]  s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;
  logic [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [11:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic m_awready, m_wready, m_arready;
  axil_arbiter_2to1 #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .i_s0_awaddr(s_awaddr[0]), .i_s0_awprot(s_prot[0]), .i_s0_awvalid(s_awvalid[0]), .o_s0_awready(s_awready[0]),
    .i_s0_wdata(s_wdata[0]), .i_s0_wstrb(s_wstrb[0]), .i_s0_wvalid(s_wvalid[0]), .o_s0_wready(s_wready[0]),
    .o_s0_bresp(s_bresp[0]), .o_s0_bvalid(s_bvalid[0]), .i_s0_bready(s_bready[0]),
    .i_s0_araddr(s_araddr[0]), .i_s0_arprot(s_prot[0]), .i_s0_arvalid(s_arvalid[0]), .o_s0_arready(s_arready[0]),
    .o_s0_rdata(s_rdata[0]), .o_s0_rresp(s_rresp[0]), .o_s0_rvalid(s_rvalid[0]), .i_s0_rready(s_rready[0]),
    .i_s1_awaddr(s_awaddr[1]), .i_s1_awprot(s_prot[1]), .i_s1_awvalid(s_awvalid[1]), .o_s1_awready(s_awready[1]),
    .i_s1_wdata(s_wdata[1]), .i_s1_wstrb(s_wstrb[1]), .i_s1_wvalid(s_wvalid[1]), .o_s1_wready(s_wready[1]),
    .o_s1_bresp(s_bresp[1]), .o_s1_bvalid(s_bvalid[1]), .i_s1_bready(s_bready[1]),
    .i_s1_araddr(s_araddr[1]), .i_s1_arprot(s_prot[1]), .i_s1_arvalid(s_arvalid[1]), .o_s1_arready(s_arready[1]),
    .o_s1_rdata(s_rdata[1]), .o_s1_rresp(s_rresp[1]), .o_s1_rvalid(s_rvalid[1]), .i_s1_rready(s_rready[1]),
    .o_m_awaddr(m_awaddr), .o_m_awprot(m_awprot), .o_m_awvalid(m_awvalid), .i_m_awready(m_awready),
    .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb), .o_m_wvalid(m_wvalid), .i_m_wready(m_wready),
    .i_m_bresp(2'b00), .i_m_bvalid(sb_bvalid), .o_m_bready(m_bready),
    .o_m_araddr(m_araddr), .o_m_arprot(m_arprot), .o_m_arvalid(m_arvalid), .i_m_arready(m_arready),
    .i_m_rdata(sb_rdata), .i_m_rresp(2'b00), .i_m_rvalid(sb_rvalid), .o_m_rready(m_rready)
  );
  // downstream RAM: accepts AW and W independently, commits the byte-merged write before answering B
  logic [31:0] mem[1024];
  logic aw_got, w_got, sb_bvalid, sb_rvalid, hold_b = 1'b0;
  logic [11:0] aw_a;
  logic [31:0] w_d, sb_rdata;
  logic [3:0]  w_s;
  int wr_count = 0;
  assign m_awready = ~aw_got;
  assign m_wready  = ~w_got;
  assign m_arready = ~sb_rvalid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; sb_bvalid <= 1'b0; sb_rvalid <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
      if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
      if (aw_got && w_got && !sb_bvalid && !hold_b) begin
        for (int b = 0; b < 4; b++) if (w_s[b]) mem[aw_a[11:2]][8*b+:8] <= w_d[8*b+:8];
        aw_got <= 1'b0; w_got <= 1'b0; sb_bvalid <= 1'b1; wr_count <= wr_count + 1;
      end
      if (sb_bvalid && m_bready) sb_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin sb_rvalid <= 1'b1; sb_rdata <= mem[m_araddr[11:2]]; end
      if (sb_rvalid && m_rready) sb_rvalid <= 1'b0;
    end
  end
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // channel-ownership model: tie goes to the pointer, pointer moves to the other port after each response
  logic wbusy = 1'b0, rbusy = 1'b0, wo = 1'b0, ro = 1'b0, wptr = 1'b0, rptr = 1'b0, overlap = 1'b0;
  int aw_log[$], ar_log[$];
  int s1_seen = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      wbusy = 1'b0; rbusy = 1'b0; wptr = 1'b0; rptr = 1'b0;
    end else begin
      if (m_awvalid && m_arvalid) overlap = 1'b1;
      if (|{s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]}) s1_seen++;
      if (wbusy) begin
        chk("w_nonowner", {s_awready[!wo], s_wready[!wo], s_bvalid[!wo]}, 0);
        chk("m_awvalid_src", m_awvalid & !s_awvalid[wo], 0);
        if (m_awvalid) chk("m_aw", {m_awprot, m_awaddr}, {s_prot[wo], s_awaddr[wo]});
        if (m_wvalid) chk("m_w", {m_wstrb, m_wdata}, {s_wstrb[wo], s_wdata[wo]});
        chk("s_bvalid", s_bvalid[wo], sb_bvalid);
        if (s_awvalid[wo] && s_awready[wo]) aw_log.push_back(int'(wo));
        if (s_bvalid[wo] && s_bready[wo]) begin wbusy = 1'b0; wptr = !wo; end
      end else begin
        chk("w_idle", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
        if (|s_awvalid) begin wo = s_awvalid[wptr] ? wptr : !wptr; wbusy = 1'b1; end
      end
      if (rbusy) begin
        chk("r_nonowner", {s_arready[!ro], s_rvalid[!ro]}, 0);
        if (m_arvalid) chk("m_ar", {m_arprot, m_araddr}, {s_prot[ro], s_araddr[ro]});
        chk("s_rvalid", s_rvalid[ro], sb_rvalid);
        if (s_rvalid[ro]) chk("s_rdata", s_rdata[ro], sb_rdata);
        if (s_arvalid[ro] && s_arready[ro]) ar_log.push_back(int'(ro));
        if (s_rvalid[ro] && s_rready[ro]) begin rbusy = 1'b0; rptr = !ro; end
      end else begin
        chk("r_idle", {m_arvalid, m_rready, s_arready, s_rvalid}, 0);
        if (|s_arvalid) begin ro = s_arvalid[rptr] ? rptr : !rptr; rbusy = 1'b1; end
      end
    end
  end
  task automatic do_write(input int p, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_delay, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, aw_hs, w_hs, b_ok = 0;
    int n = 0;
    s_awaddr[p] = a; s_wdata[p] = d; s_wstrb[p] = s; s_wvalid[p] = 1'b1; s_bready[p] = 1'b1;
    if (aw_delay == 0) s_awvalid[p] = 1'b1;
    resp = 2'bxx;
    while (!(aw_ok && w_ok) && n < 200) begin
      @(negedge clk);
      aw_hs = s_awvalid[p] & s_awready[p];
      w_hs = s_wvalid[p] & s_wready[p];
      @(posedge clk); #1;
      if (aw_hs) begin s_awvalid[p] = 1'b0; aw_ok = 1; end
      if (w_hs) begin s_wvalid[p] = 1'b0; w_ok = 1; end
      n++;
      if (n == aw_delay) s_awvalid[p] = 1'b1;
    end
    s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0;
    chk("aw_w_done", {aw_ok, w_ok}, 2'b11);
    n = 0;
    while (!b_ok && n < 200) begin
      @(negedge clk);
      if (s_bvalid[p]) begin resp = s_bresp[p]; b_ok = 1; end
      @(posedge clk); #1;
      n++;
    end
    s_bready[p] = 1'b0;
    chk("b_seen", b_ok, 1);
  endtask
  task automatic do_read(input int p, input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0, hs;
    int n = 0;
    s_araddr[p] = a; s_arvalid[p] = 1'b1; s_rready[p] = 1'b1;
    d = 'x; resp = 'x;
    while (!ok && n < 200) begin
      @(negedge clk);
      hs = s_arvalid[p] & s_arready[p];
      @(posedge clk); #1;
      if (hs) begin s_arvalid[p] = 1'b0; ok = 1; end
      n++;
    end
    s_arvalid[p] = 1'b0;
    chk("ar_done", ok, 1);
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (s_rvalid[p]) begin d = s_rdata[p]; resp = s_rresp[p]; ok = 1; end
      @(posedge clk); #1;
      n++;
    end
    s_rready[p] = 1'b0;
    chk("r_seen", ok, 1);
  endtask
  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask
  logic [31:0] shadow[1024];
  int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  initial begin
    logic [1:0] resp, resp1;
    logic [31:0] rd, rd1;
    int wc, zeros;
    s_prot[0] = 3'd1; s_prot[1] = 3'd2;
    s_awaddr[0] = '0; s_awaddr[1] = '0; s_araddr[0] = '0; s_araddr[1] = '0;
    s_wdata[0] = '0; s_wdata[1] = '0; s_wstrb[0] = '0; s_wstrb[1] = '0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11; s_bready = 2'b11; s_rready = 2'b11;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                          s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
    #2 rst = 1'b0;
    // single write then readback; port 1 must see nothing
    s1_seen = 0;
    do_write(0, 12'h004, 32'hCA55E77E, 4'hF, 0, resp);
    chk("single_bresp", resp, 2'b00);
    do_read(0, 12'h004, rd, resp);
    chk("single_rdata", {resp, rd}, {2'b00, 32'hCA55E77E});
    chk("s1_quiet", s1_seen, 0);
    // same-cycle contention on the write channel
    do_reset();
    aw_log.delete();
    fork
      do_write(0, 12'h010, 32'h11111111, 4'hF, 0, resp);
      do_write(1, 12'h010, 32'h22222222, 4'hF, 0, resp1);
    join
    chk("cont_bresp", {resp, resp1}, 4'b0000);
    chk("cont_count", aw_log.size(), 2);
    if (aw_log.size() == 2) chk("cont_order", {aw_log[0][1:0], aw_log[1][1:0]}, 4'b0001);
    do_read(0, 12'h010, rd, resp);
    chk("cont_rdata", rd, 32'h22222222);
    // fairness on the read channel
    do_reset();
    do_write(0, 12'h100, 32'h00000100, 4'hF, 0, resp);
    do_write(1, 12'h200, 32'h00000200, 4'hF, 0, resp);
    ar_log.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        logic [31:0] d0; logic [1:0] r0;
        do_read(0, 12'h100, d0, r0);
        chk("fair_rd0", d0, 32'h00000100);
      end
      for (int i = 0; i < 4; i++) begin
        logic [31:0] d1; logic [1:0] r1;
        do_read(1, 12'h200, d1, r1);
        chk("fair_rd1", d1, 32'h00000200);
      end
    join
    chk("fair_count", ar_log.size(), 8);
    zeros = 0;
    foreach (ar_log[i]) begin
      if (ar_log[i] == 0) zeros++;
      if (i < 8) chk("fair_order", ar_log[i], exp_order[i]);
    end
    chk("fair_p0_grants", zeros, 4);
    // concurrent write and read on different ports
    do_reset();
    do_write(1, 12'h000, 32'hDEADBEEF, 4'hF, 0, resp);
    overlap = 1'b0;
    fork
      do_write(0, 12'h008, 32'h12345678, 4'hF, 0, resp);
      do_read(1, 12'h000, rd, resp1);
    join
    chk("conc_bresp", resp, 2'b00);
    chk("conc_rdata", {resp1, rd}, {2'b00, 32'hDEADBEEF});
    chk("conc_overlap", overlap, 1'b1);
    do_read(1, 12'h008, rd, resp);
    chk("conc_wdata", rd, 32'h12345678);
    // W presented three cycles ahead of AW
    wc = wr_count;
    do_write(0, 12'h00C, 32'h0BADF00D, 4'hF, 3, resp);
    chk("wfirst_bresp", resp, 2'b00);
    chk("wfirst_writes", wr_count - wc, 1);
    do_read(0, 12'h00C, rd, resp);
    chk("wfirst_rdata", rd, 32'h0BADF00D);
    // reset while parked in the response phase
    hold_b = 1'b1;
    s_awaddr[0] = 12'h014; s_wdata[0] = 32'hFFFF0000; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    @(negedge clk);
    chk("midrst_bready_pre", m_bready, 1'b1);
    #2 rst = 1'b1;
    #1 chk("midrst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                           s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
    s_bready[0] = 1'b0; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_write(1, 12'h018, 32'h5A5A5A5A, 4'hF, 0, resp);
    chk("midrst_bresp", resp, 2'b00);
    do_read(1, 12'h018, rd, resp);
    chk("midrst_rdata", rd, 32'h5A5A5A5A);
    // randomized traffic, port 0 in the lower half, port 1 in the upper half
    do_reset();
    foreach (shadow[i]) shadow[i] = '0;
    fork
      for (int i = 0; i < 512; i++) begin
        logic [9:0] ix; logic [31:0] d, q; logic [3:0] s; logic [1:0] r;
        ix = {1'b0, 9'($urandom)}; d = $urandom; s = 4'($urandom);
        do_write(0, {ix, 2'b00}, d, s, 0, r);
        chk("rnd0_bresp", r, 2'b00);
        for (int b = 0; b < 4; b++) if (s[b]) shadow[ix][8*b+:8] = d[8*b+:8];
        do_read(0, {ix, 2'b00}, q, r);
        chk("rnd0_rdata", {r, q}, {2'b00, shadow[ix]});
      end
      for (int i = 0; i < 512; i++) begin
        logic [9:0] ix; logic [31:0] d, q; logic [3:0] s; logic [1:0] r;
        ix = {1'b1, 9'($urandom)}; d = $urandom; s = 4'($urandom);
        do_write(1, {ix, 2'b00}, d, s, 0, r);
        chk("rnd1_bresp", r, 2'b00);
        for (int b = 0; b < 4; b++) if (s[b]) shadow[ix][8*b+:8] = d[8*b+:8];
        do_read(1, {ix, 2'b00}, q, r);
        chk("rnd1_rdata", {r, q}, {2'b00, shadow[ix]});
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/axil_arbiter_2to1.md
Name: axil_arbiter_2to1

Overview:
- Two-requester AXI-Lite arbiter that shares one AXI-Lite slave, typically an AxilRam instance or an AxilReg-buffered RAM, between two masters.
- Write and read channels are arbitered independently, so one write and one read can be in flight at once.
- Each channel carries at most one outstanding transaction.
- Grants are round-robin per channel. Responses are routed back to the port that owns the current grant.

Parameters:
- ADDR_W, 12, AXI-Lite address width on all three ports (MEM_W+2 when driving an AxilRam).

Ports:
- clk, input, 1, sole clock for all logic; the clk/rstn signals carried inside the interfaces are not used.
- rst, input, 1, asynchronous active-high reset.
- s0, AxiLite slave side, ADDR_W, requester 0.
- s1, AxiLite slave side, ADDR_W, requester 1.
- m, AxiLite master side, ADDR_W, shared downstream slave.

Behaviour:
- Reset values (rst high, asynchronous):
  - m.awvalid, m.wvalid, m.bready, m.arvalid and m.rready are 0.
  - On both slave ports, all ready signals and bvalid/rvalid are 0.
  - Write and read FSMs are in IDLE; both priority pointers point at port 0.
- Write FSM states: W_IDLE, W_FWD, W_RESP.
  - W_IDLE: a port requests when its awvalid is high. If only one port requests, it wins. If both request, the port named by the write pointer wins. The winner is registered as wgrant and the FSM moves to W_FWD on the next clock.
  - W_FWD:
    - m.awaddr/awprot/wdata/wstrb are muxed combinationally from the granted port. m.awvalid and m.wvalid are driven from the granted port's valids, each gated by a sticky "already accepted" flag.
    - Granted port sX.awready = m.awready and sX.wready = m.wready, with the same gating. The non-granted port sees all readies at 0.
    - AW and W may complete in either order or in the same cycle.
    - When both handshakes have completed, go to W_RESP and clear the flags.
  - W_RESP: m.bready follows the granted port's bready, and the granted port's bvalid/bresp follow m. On the B handshake, go to W_IDLE and set the write pointer to the other port (the port not just served).
- Read FSM states: R_IDLE, R_FWD, R_DATA.
  - Arbitration, grant registration and pointer update on R handshake are identical to the write FSM, keyed on arvalid.
  - R_FWD: forwards AR only. On the AR handshake, go to R_DATA.
  - R_DATA: routes rvalid/rdata/rresp to the granted port and rready back to m. On the R handshake, return to R_IDLE.
- Latency:
  - Request-valid to m.*valid is 1 cycle, for the grant register.
  - All other paths are combinational passthrough; no data is buffered.
- Idle-state outputs: no m.*valid is asserted in IDLE. A request that drops before grant is a protocol violation and needs no defined handling.
- A new grant never occurs in the cycle the previous response handshakes. Minimum spacing is one IDLE cycle between back-to-back transactions.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- Read and write are independent. A read may be granted to port 1 while port 0 owns the write channel.
- Non-granted port: its handshake signals stay low until it is granted. The port must hold its valids stable while waiting, per AXI.
- Reset mid-transaction: all FSMs return to IDLE and all valids drop asynchronously. In-flight transactions are abandoned, and the downstream slave is reset by the same reset domain.

Decomposition:
- Package axil_arb_pkg holds:
  - typedef enum wr_state_t {W_IDLE, W_FWD, W_RESP};
  - typedef enum rd_state_t {R_IDLE, R_FWD, R_DATA};
  - constant PORT0 = 1'b0.
- Sub-module rr_pick2 is natural:
  - Inputs: req[1:0], ptr.
  - Outputs: grant, any.
  - Instantiated once for the write channel and once for the read channel.

Test Plan:
- Single write: s0 writes 0xCA55E77E to address 0x004 with strobe 0xF, then reads it back. Required: bresp OKAY and rdata 0xCA55E77E. s1 readies stay 0 throughout.
- Contention: s0 and s1 both raise awvalid in the same cycle, s0 to 0x010 with 0x11111111 and s1 to 0x010 with 0x22222222. Required: s0 is served first after reset, then s1. A read of 0x010 returns 0x22222222.
- Fairness: both ports issue 8 continuous reads. Required: grant order is 0,1,0,1,...; each port gets 4 grants and no port is starved.
- Concurrency and W-before-AW:
  - s0 writes 0x008 while s1 reads 0x000 (holding 0xDEADBEEF) simultaneously. Required: both complete, rdata is 0xDEADBEEF, and m.arvalid and m.awvalid overlap in time.
  - In a separate case, s0 presents wvalid 3 cycles before awvalid. Required: exactly one m write is issued, with the data intact.
- Reset mid-op: assert rst while in W_RESP with m.bvalid held low. Required: all valids and readies are 0 immediately. After release, a fresh s1 write completes with OKAY.
- Randomized: 1024 random addresses, strobes and data, split across both ports with a shadow model. Required: every read matches the byte-merged expected value and every response is OKAY.
